// File: rtl/fir_decim.sv
// Decimating FIR low-pass stage: loads DECIMATION samples, runs one
// serial MAC pass over the history, then pushes one filtered sample.
module fir_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 32,
  parameter int DECIMATION = 8,
  parameter int BITS       = 10,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = '{default: '0}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_din,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_dout,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int TW = $clog2(NUM_TAPS);
  localparam int CW = $clog2(DECIMATION + 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIMATION - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_WRITE
  } state_t;

  state_t state;

  logic signed [DATA_WIDTH-1:0] x [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] acc;
  logic [TW-1:0] tap;
  logic [CW-1:0] load_cnt;

  logic signed [DATA_WIDTH-1:0] x_sel;
  logic signed [DATA_WIDTH-1:0] h_sel;
  logic signed [DATA_WIDTH-1:0] deq;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] bias;
  logic signed [PW-1:0] biased;

  // Negative products get a 2^BITS-1 bias so the shift rounds toward zero.
  always_comb begin
    x_sel = x[tap];
    h_sel = COEFFS[tap];
    prod  = $signed({{DATA_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel})
          * $signed({{DATA_WIDTH{h_sel[DATA_WIDTH-1]}}, h_sel});
    bias  = '0;
    if (prod[PW-1]) begin
      bias[BITS-1:0] = '1;
    end
    biased = prod + bias;
    deq    = DATA_WIDTH'(biased >>> BITS);
  end

  assign in_rd_en  = (state == S_LOAD) && !in_empty;
  assign out_wr_en = (state == S_WRITE) && !out_full;
  assign out_dout  = acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_LOAD;
      acc      <= '0;
      tap      <= '0;
      load_cnt <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x[k] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_rd_en) begin
            x[0] <= in_din;
            for (int k = 1; k < NUM_TAPS; k++) begin
              x[k] <= x[k-1];
            end
            if (load_cnt == CNT_LAST) begin
              load_cnt <= '0;
              acc      <= '0;
              tap      <= '0;
              state    <= S_MAC;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc <= acc + deq;
          tap <= tap + 1'b1;
          if (tap == TAP_LAST) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (out_wr_en) begin
            state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: ramp-coefficient instance plus a
// constant-coefficient instance for the round-toward-zero case.
module tb_fir_decim;

  localparam logic signed [31:0] H_RAMP [32] = '{
    32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd5,  32'sd6,  32'sd7,  32'sd8,
    32'sd9,  32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16,
    32'sd17, 32'sd18, 32'sd19, 32'sd20, 32'sd21, 32'sd22, 32'sd23, 32'sd24,
    32'sd25, 32'sd26, 32'sd27, 32'sd28, 32'sd29, 32'sd30, 32'sd31, 32'sd32
  };
  localparam logic signed [31:0] H_THREE [32] = '{default: 32'sd3};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_din = '0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] out_dout;
  logic        out_full = 1'b0;
  logic        out_wr_en;

  logic [31:0] din3 = '0;
  logic        empty3 = 1'b1;
  logic        rd3;
  logic [31:0] dout3;
  logic        full3 = 1'b0;
  logic        wr3;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int          rq[$];
  logic [31:0] wq[$];
  int          wc[$];
  logic [31:0] w3[$];

  fir_decim #(
    .DATA_WIDTH(32), .NUM_TAPS(32), .DECIMATION(8), .BITS(10),
    .COEFFS(H_RAMP)
  ) dut (
    .clock(clock), .reset(reset),
    .in_din(in_din), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_dout(out_dout), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  fir_decim #(
    .DATA_WIDTH(32), .NUM_TAPS(32), .DECIMATION(8), .BITS(10),
    .COEFFS(H_THREE)
  ) dut3 (
    .clock(clock), .reset(reset),
    .in_din(din3), .in_empty(empty3), .in_rd_en(rd3),
    .out_dout(dout3), .out_full(full3), .out_wr_en(wr3)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (in_rd_en) rq.push_back(cyc);
    if (out_wr_en) begin
      wq.push_back(out_dout);
      wc.push_back(cyc);
    end
    if (wr3) w3.push_back(dout3);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    rq.delete();
    wq.delete();
    wc.delete();
    w3.delete();
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic feed(input bit sel, input int n, input logic [31:0] v0,
                      input logic [31:0] vrest, input bit stall);
    int idx = 0;
    int g = 0;
    bit took;
    logic [31:0] d;
    bit e;
    while (idx < n && g < 4000) begin
      d = (idx == 0) ? v0 : vrest;
      e = stall && ($urandom_range(0, 2) == 0);
      if (sel) begin
        din3 = d;
        empty3 = e;
      end else begin
        in_din = d;
        in_empty = e;
      end
      @(negedge clock);
      took = sel ? rd3 : in_rd_en;
      tick();
      if (took) idx++;
      g++;
    end
    in_empty = 1'b1;
    empty3 = 1'b1;
    n_total++;
    if (idx !== n) $display("FAIL feed_done: consumed %0d, need %0d", idx, n);
    else n_pass++;
  endtask

  task automatic wait_writes(input bit sel, input int n);
    int g = 0;
    while ((sel ? w3.size() : wq.size()) < n && g < 1000) begin
      tick();
      g++;
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_empty = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    n_total++;
    if (out_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", out_wr_en);
    else n_pass++;
    n_total++;
    if (out_dout !== 32'h0) $display("FAIL rst_dout: got %h want 0", out_dout);
    else n_pass++;
    n_total++;
    if (in_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", in_rd_en);
    else n_pass++;
    tick();
    in_din = '0;
    in_empty = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    n_total++;
    if (in_rd_en !== 1'b1) $display("FAIL rel_rd_en: got %b want 1", in_rd_en);
    else n_pass++;
    n_total++;
    if (out_wr_en !== 1'b0) $display("FAIL rel_wr_en: got %b want 0", out_wr_en);
    else n_pass++;
    tick();
    in_empty = 1'b1;
    rst_pulse();
  endtask

  task automatic test_impulse();
    logic [31:0] exp [5] = '{32'h8, 32'h10, 32'h18, 32'h20, 32'h0};
    logic [31:0] got;
    int lat;
    int gap;
    rst_pulse();
    feed(0, 40, 32'h400, 32'h0, 0);
    wait_writes(0, 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      n_total++;
      if (got !== exp[i]) $display("FAIL imp_out%0d: got %h want %h", i, got, exp[i]);
      else n_pass++;
    end
    lat = (wc.size() > 0 && rq.size() > 0) ? wc[0] - rq[0] : -1;
    n_total++;
    if (lat !== 40) $display("FAIL imp_latency: got %0d want 40", lat);
    else n_pass++;
    for (int i = 1; i < 5; i++) begin
      gap = (i < wc.size()) ? wc[i] - wc[i-1] : -1;
      n_total++;
      if (gap !== 41) $display("FAIL imp_gap%0d: got %0d want 41", i, gap);
      else n_pass++;
    end
    n_total++;
    if (wq.size() !== 5) $display("FAIL imp_count: got %0d want 5", wq.size());
    else n_pass++;
  endtask

  task automatic test_dc();
    logic [31:0] exp [5] = '{32'd36, 32'd136, 32'd300, 32'd528, 32'd528};
    logic [31:0] got;
    rst_pulse();
    feed(0, 40, 32'h400, 32'h400, 0);
    wait_writes(0, 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      n_total++;
      if (got !== exp[i]) $display("FAIL dc_out%0d: got %0d want %0d", i, got, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_trunc();
    logic [31:0] exp [4] = '{32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFFFFE8, 32'hFFFFFFE0};
    logic [31:0] got;
    rst_pulse();
    feed(1, 32, 32'hFFFFFE00, 32'hFFFFFE00, 0);
    wait_writes(1, 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < w3.size()) ? w3[i] : 'x;
      n_total++;
      if (got !== exp[i]) $display("FAIL trunc_out%0d: got %h want %h", i, got, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stalls();
    logic [31:0] exp [5] = '{32'h8, 32'h10, 32'h18, 32'h20, 32'h0};
    logic [31:0] got;
    bit hold_ok;
    int g;
    int held_writes;
    rst_pulse();
    hold_ok = 1'b1;
    held_writes = -1;
    fork
      feed(0, 40, 32'h400, 32'h0, 1);
      begin
        g = 0;
        while (rq.size() < 16 && g < 3000) begin
          tick();
          g++;
        end
        out_full = 1'b1;
        repeat (32) tick();
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          if (out_wr_en !== 1'b0 || out_dout !== 32'h10) hold_ok = 1'b0;
          tick();
        end
        held_writes = wq.size();
        out_full = 1'b0;
      end
    join
    wait_writes(0, 5);
    n_total++;
    if (hold_ok !== 1'b1) $display("FAIL stall_hold: stable %b want 1", hold_ok);
    else n_pass++;
    n_total++;
    if (held_writes !== 1) $display("FAIL stall_held_writes: got %0d want 1", held_writes);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      n_total++;
      if (got !== exp[i]) $display("FAIL stall_out%0d: got %h want %h", i, got, exp[i]);
      else n_pass++;
    end
    n_total++;
    if (wq.size() !== 5) $display("FAIL stall_count: got %0d want 5", wq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_mac();
    logic [31:0] exp [5] = '{32'h8, 32'h10, 32'h18, 32'h20, 32'h0};
    logic [31:0] got;
    rst_pulse();
    feed(0, 16, 32'h400, 32'h0, 0);
    repeat (9) tick();
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (out_wr_en !== 1'b0) $display("FAIL mid_rst_wr_en: got %b want 0", out_wr_en);
    else n_pass++;
    n_total++;
    if (out_dout !== 32'h0) $display("FAIL mid_rst_dout: got %h want 0", out_dout);
    else n_pass++;
    tick();
    reset = 1'b1;
    repeat (60) tick();
    n_total++;
    if (wq.size() !== 1) $display("FAIL mid_aborted: writes %0d want 1", wq.size());
    else n_pass++;
    clear_logs();
    feed(0, 40, 32'h400, 32'h0, 0);
    wait_writes(0, 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < wq.size()) ? wq[i] : 'x;
      n_total++;
      if (got !== exp[i]) $display("FAIL mid_out%0d: got %h want %h", i, got, exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_trunc();
    test_stalls();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
